// File: rtl/result_monitor.sv
// End-of-test monitor on the core data-memory bus: decides pass/fail/timeout from the
// store that hits the result address and keeps sticky status plus store statistics.
module result_monitor #(
    parameter logic [31:0] RESULT_ADR     = 32'd252,
    parameter logic [31:0] PASS_VALUE     = 32'h0000_1000,
    parameter bit          STRICT         = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [CNT_W-1:0] store_count,
    output logic [31:0]      last_adr,
    output logic [31:0]      last_data,
    output logic [31:0]      cycles
);

    localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StPass, StFail, StTimeout} state_e;

    state_e           r_state;
    logic             r_done;
    logic             r_pass;
    logic             r_fail;
    logic             r_timeout;
    logic [CNT_W-1:0] r_store_count;
    logic [31:0]      r_last_adr;
    logic [31:0]      r_last_data;
    logic [31:0]      r_cycles;

    logic w_adr_hit;
    logic w_decisive;
    logic w_data_ok;
    logic w_cnt_max;
    logic w_tmo_hit;

    assign w_adr_hit  = (DataAdr == RESULT_ADR);
    assign w_data_ok  = (WriteData == PASS_VALUE);
    assign w_decisive = MemWrite && (STRICT || w_adr_hit);
    assign w_cnt_max  = (r_store_count == {CNT_W{1'b1}});
    assign w_tmo_hit  = (r_cycles == TmoLast);

    // Flags are registered alongside the state so outputs never see the bus combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StRun;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_store_count <= '0;
            r_last_adr    <= '0;
            r_last_data   <= '0;
            r_cycles      <= '0;
        end else if (r_state == StRun) begin
            r_cycles <= r_cycles + 32'd1;
            if (MemWrite) begin
                if (!w_cnt_max) begin
                    r_store_count <= r_store_count + CNT_W'(1);
                end
                r_last_adr  <= DataAdr;
                r_last_data <= WriteData;
            end
            // A decisive store in the final cycle takes priority over the timeout.
            if (w_decisive) begin
                r_done <= 1'b1;
                if (w_adr_hit && w_data_ok) begin
                    r_state <= StPass;
                    r_pass  <= 1'b1;
                end else begin
                    r_state <= StFail;
                    r_fail  <= 1'b1;
                end
            end else if (w_tmo_hit) begin
                r_state   <= StTimeout;
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign store_count = r_store_count;
    assign last_adr    = r_last_adr;
    assign last_data   = r_last_data;
    assign cycles      = r_cycles;

endmodule

// File: tb/tb_result_monitor.sv
// Bench for result_monitor: four differently configured instances share one bus and are
// compared against a behavioural outcome model plus directed constant expectations.
module tb_result_monitor;

    localparam logic [31:0] PV = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;

    always #5 clk = ~clk;

    logic [3:0]        obs_done, obs_pass, obs_fail, obs_to;
    logic [15:0]       cnt0, cnt1, cnt3;
    logic [1:0]        cnt2;
    logic [3:0][31:0]  obs_adr, obs_data, obs_cyc;

    // inst0: defaults; inst1: strict, short timeout; inst2: relaxed, 2-bit counter; inst3: relaxed
    result_monitor u_dut0 (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(obs_done[0]), .pass(obs_pass[0]), .fail(obs_fail[0]), .timeout(obs_to[0]),
        .store_count(cnt0), .last_adr(obs_adr[0]), .last_data(obs_data[0]), .cycles(obs_cyc[0])
    );
    result_monitor #(.STRICT(1'b1), .TIMEOUT_CYCLES(50), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(obs_done[1]), .pass(obs_pass[1]), .fail(obs_fail[1]), .timeout(obs_to[1]),
        .store_count(cnt1), .last_adr(obs_adr[1]), .last_data(obs_data[1]), .cycles(obs_cyc[1])
    );
    result_monitor #(.STRICT(1'b0), .TIMEOUT_CYCLES(50), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(obs_done[2]), .pass(obs_pass[2]), .fail(obs_fail[2]), .timeout(obs_to[2]),
        .store_count(cnt2), .last_adr(obs_adr[2]), .last_data(obs_data[2]), .cycles(obs_cyc[2])
    );
    result_monitor #(.STRICT(1'b0), .TIMEOUT_CYCLES(10000), .CNT_W(16)) u_dut3 (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(obs_done[3]), .pass(obs_pass[3]), .fail(obs_fail[3]), .timeout(obs_to[3]),
        .store_count(cnt3), .last_adr(obs_adr[3]), .last_data(obs_data[3]), .cycles(obs_cyc[3])
    );

    // Reference model: outcome 0=running, 1=pass, 2=fail, 3=timeout
    bit          p_strict [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int unsigned p_tmo    [4] = '{10000, 50, 50, 10000};
    int unsigned p_cmax   [4] = '{65535, 65535, 3, 65535};
    int unsigned m_st     [4];
    int unsigned m_cnt    [4];
    logic [31:0] m_adr    [4];
    logic [31:0] m_data   [4];
    logic [31:0] m_cyc    [4];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [15:0] get_cnt(int i);
        case (i)
            0:       return cnt0;
            1:       return cnt1;
            2:       return {14'd0, cnt2};
            default: return cnt3;
        endcase
    endfunction

    function automatic logic [115:0] obs_vec(int i);
        return {obs_done[i], obs_pass[i], obs_fail[i], obs_to[i], get_cnt(i),
                obs_adr[i], obs_data[i], obs_cyc[i]};
    endfunction

    function automatic logic [115:0] exp_vec(int i);
        logic [15:0] c;
        c = m_cnt[i][15:0];
        return {m_st[i] != 0, m_st[i] == 1, m_st[i] == 2, m_st[i] == 3, c,
                m_adr[i], m_data[i], m_cyc[i]};
    endfunction

    function automatic void model_step(int i, logic rst, logic mw, logic [31:0] a, logic [31:0] d);
        if (rst) begin
            m_st[i] = 0; m_cnt[i] = 0; m_adr[i] = 0; m_data[i] = 0; m_cyc[i] = 0;
        end else if (m_st[i] == 0) begin
            if (mw) begin
                m_cnt[i]  = (m_cnt[i] < p_cmax[i]) ? m_cnt[i] + 1 : p_cmax[i];
                m_adr[i]  = a;
                m_data[i] = d;
                if (p_strict[i] || a == 252) m_st[i] = (a == 252 && d == PV) ? 1 : 2;
            end
            if (m_st[i] == 0 && m_cyc[i] + 1 == p_tmo[i]) m_st[i] = 3;
            m_cyc[i] = m_cyc[i] + 1;
        end
    endfunction

    task automatic tick(input logic rst, input logic mw, input logic [31:0] a, input logic [31:0] d);
        reset = rst; MemWrite = mw; DataAdr = a; WriteData = d;
        @(posedge clk);
        for (int i = 0; i < 4; i++) model_step(i, rst, mw, a, d);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 32'd252, PV);
        tick(1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_vec(i) !== 116'd0)
                $display("FAIL reset inst%0d got=%h exp=%h", i, obs_vec(i), 116'd0);
            else n_pass++;
        end
    endtask

    task automatic test_pass();
        tick(1'b0, 1'b1, 32'd252, PV);
        tick(1'b0, 1'b0, 32'd0, 32'd0);
        n_checks++;
        if ({obs_done[0], obs_pass[0], cnt0, obs_adr[0], obs_data[0]} !== {2'b11, 16'd1, 32'd252, PV})
            $display("FAIL pass_store got=%b/%b cnt=%0d adr=%0d data=%h exp=1/1 cnt=1 adr=252 data=%h",
                     obs_done[0], obs_pass[0], cnt0, obs_adr[0], obs_data[0], PV);
        else n_pass++;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, k[0], 32'd248, 32'(k));
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (obs_vec(i) !== exp_vec(i))
                    $display("FAIL pass_sticky inst%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
                else n_pass++;
            end
        end
    endtask

    task automatic test_strict_fail();
        tick(1'b1, 1'b0, 32'd0, 32'd0);
        tick(1'b0, 1'b1, 32'd248, PV);
        n_checks++;
        if ({obs_fail[1], obs_pass[1], obs_adr[1]} !== {2'b10, 32'd248})
            $display("FAIL strict_wrong_adr got fail=%b pass=%b adr=%0d exp fail=1 pass=0 adr=248",
                     obs_fail[1], obs_pass[1], obs_adr[1]);
        else n_pass++;
        tick(1'b0, 1'b1, 32'd252, PV);
        n_checks++;
        if ({obs_fail[1], obs_pass[1], cnt1} !== {2'b10, 16'd1})
            $display("FAIL strict_after got fail=%b pass=%b cnt=%0d exp 1 0 1",
                     obs_fail[1], obs_pass[1], cnt1);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_vec(i) !== exp_vec(i))
                $display("FAIL strict_model inst%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
            else n_pass++;
        end
    endtask

    task automatic test_nonstrict_fail();
        tick(1'b1, 1'b0, 32'd0, 32'd0);
        tick(1'b0, 1'b1, 32'd96, 32'h5);
        tick(1'b0, 1'b1, 32'd100, 32'h7);
        n_checks++;
        if (obs_done[3] !== 1'b0)
            $display("FAIL nonstrict_running got done=%b exp done=0", obs_done[3]);
        else n_pass++;
        tick(1'b0, 1'b1, 32'd252, 32'h0000_0FFF);
        n_checks++;
        if ({obs_fail[3], cnt3, obs_data[3]} !== {1'b1, 16'd3, 32'h0000_0FFF})
            $display("FAIL nonstrict_fail got fail=%b cnt=%0d data=%h exp fail=1 cnt=3 data=00000fff",
                     obs_fail[3], cnt3, obs_data[3]);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_vec(i) !== exp_vec(i))
                $display("FAIL nonstrict_model inst%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        tick(1'b1, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 49; k++) tick(1'b0, 1'b0, 32'd0, 32'd0);
        n_checks++;
        if ({obs_to[1], obs_done[1]} !== 2'b00)
            $display("FAIL timeout_early got to=%b done=%b exp 0 0", obs_to[1], obs_done[1]);
        else n_pass++;
        tick(1'b0, 1'b0, 32'd0, 32'd0);
        n_checks++;
        if ({obs_to[1], obs_to[2], obs_cyc[1]} !== {2'b11, 32'd50})
            $display("FAIL timeout_edge got to=%b%b cycles=%0d exp 11 cycles=50",
                     obs_to[1], obs_to[2], obs_cyc[1]);
        else n_pass++;
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 32'd252, PV);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_vec(i) !== exp_vec(i))
                $display("FAIL timeout_hold inst%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
            else n_pass++;
        end
        tick(1'b1, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 49; k++) tick(1'b0, 1'b0, 32'd0, 32'd0);
        tick(1'b0, 1'b1, 32'd252, PV);
        n_checks++;
        if ({obs_pass[1], obs_to[1], obs_pass[2], obs_to[2], obs_cyc[1]} !== {4'b1010, 32'd50})
            $display("FAIL timeout_store_wins got pass/to=%b%b %b%b cycles=%0d exp 10 10 cycles=50",
                     obs_pass[1], obs_to[1], obs_pass[2], obs_to[2], obs_cyc[1]);
        else n_pass++;
    endtask

    task automatic test_reset_wins();
        tick(1'b1, 1'b0, 32'd0, 32'd0);
        tick(1'b0, 1'b1, 32'd252, PV);
        tick(1'b1, 1'b1, 32'd252, PV);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_vec(i) !== 116'd0)
                $display("FAIL reset_wins inst%0d got=%h exp=%h", i, obs_vec(i), 116'd0);
            else n_pass++;
        end
        tick(1'b0, 1'b0, 32'd0, 32'd0);
        n_checks++;
        if ({obs_done[0], cnt0, obs_cyc[0]} !== {1'b0, 16'd0, 32'd1})
            $display("FAIL reset_release got done=%b cnt=%0d cycles=%0d exp 0 0 1",
                     obs_done[0], cnt0, obs_cyc[0]);
        else n_pass++;
    endtask

    task automatic test_saturate();
        tick(1'b1, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 32'd0, 32'(k));
        n_checks++;
        if ({cnt2, obs_done[2], cnt3} !== {2'd3, 1'b0, 16'd5})
            $display("FAIL saturate got cnt2=%0d done=%b cnt3=%0d exp 3 0 5", cnt2, obs_done[2], cnt3);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        mw;
        logic [31:0] a, d;
        for (int r = 0; r < 8; r++) begin
            tick(1'b1, 1'b0, 32'd0, 32'd0);
            for (int k = 0; k < 70; k++) begin
                mw = ($urandom_range(0, 9) < 3);
                case ($urandom_range(0, 9))
                    0:       a = 32'd252;
                    1:       a = 32'd248;
                    2:       a = 32'd0;
                    3:       a = 32'd252 | 32'h1_0000;
                    default: a = $urandom;
                endcase
                d = $urandom_range(0, 1) ? PV : $urandom;
                tick((r == 7 && k == 40), mw, a, d);
                for (int i = 0; i < 4; i++) begin
                    n_checks++;
                    if (obs_vec(i) !== exp_vec(i))
                        $display("FAIL random inst%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_strict_fail();
        test_nonstrict_fail();
        test_timeout();
        test_reset_wins();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/result_monitor.md
# result_monitor

Synthesizable end-of-test monitor on the multi-cycle RISC-V core's data-memory bus, directly downstream of `top`. It samples the core's store strobe, address and data every cycle and decides the test outcome when the core stores to the result address. It raises sticky pass/fail/timeout flags, counts stores and captures the deciding store. Simulation benches and FPGA builds then read one status set instead of open-coding address/data checks.

## Interface
- `RESULT_ADR`, 252: byte address whose store decides the outcome.
- `PASS_VALUE`, 32'h00001000: data value that means pass.
- `STRICT`, 1: 1 = the first store to any address decides; 0 = only stores to `RESULT_ADR` decide, other stores are counted only.
- `TIMEOUT_CYCLES`, 10000: cycles in RUN with no decision before TIMEOUT; must be ≥ 2.
- `CNT_W`, 16: width of the store counter.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; same net as the core reset.
- `MemWrite`  in  1  core store strobe; one store per high cycle.
- `DataAdr`  in  32  store byte address.
- `WriteData`  in  32  store data.
- `done`  out  1  outcome decided (PASS, FAIL or TIMEOUT); sticky.
- `pass`  out  1  outcome is pass; sticky.
- `fail`  out  1  decisive store carried a wrong address or wrong data; sticky.
- `timeout`  out  1  no decision within `TIMEOUT_CYCLES`; sticky.
- `store_count`  out  CNT_W  stores seen in RUN, saturating at all-ones.
- `last_adr`  out  32  address of the most recent store seen in RUN.
- `last_data`  out  32  data of the most recent store seen in RUN.
- `cycles`  out  32  cycles spent in RUN, frozen on leaving RUN.

## Operation
- States: RUN, PASS, FAIL, TIMEOUT. Reset enters RUN. PASS, FAIL and TIMEOUT are terminal until reset.
- In RUN, a store is a cycle with `MemWrite`=1.
  - `store_count` increments by 1 and saturates at 2^CNT_W−1.
  - `last_adr` and `last_data` capture that store's address and data.
- A store is decisive when `STRICT`=1, or when `DataAdr`==`RESULT_ADR`.
- Decisive store:
  - `DataAdr`==`RESULT_ADR` and `WriteData`==`PASS_VALUE` → PASS.
  - Any other decisive store → FAIL. Under `STRICT`=1 this includes a correct value at a wrong address.
- Non-decisive store: counted and captured; state stays RUN.
- `cycles` increments by 1 every cycle in RUN.
- When `cycles`==`TIMEOUT_CYCLES`−1 and the cycle holds no decisive store → TIMEOUT.
- Outputs are pure state decode:
  - `done` = not RUN.
  - `pass`, `fail` and `timeout` are one-hot with their state.
- In terminal states:
  - `MemWrite` is ignored.
  - `store_count`, `last_adr`, `last_data` and `cycles` hold their values.
- Address compare uses the full 32-bit address, with no masking.

## Timing
- Reset values:
  - `done`, `pass`, `fail`, `timeout` = 0.
  - `store_count` = 0, `last_adr` = 0, `last_data` = 0, `cycles` = 0.
- Latency: a decisive store sampled at edge N sets its flag from edge N onward, so the flag is visible one cycle after `MemWrite` is first high. `store_count`, `last_adr` and `last_data` update at the same edge N.
- Timeout: with no decisive store, `timeout` rises at edge `TIMEOUT_CYCLES` after reset release. `cycles` freezes at `TIMEOUT_CYCLES`.
- Simultaneous events:
  - A decisive store in the timeout cycle wins: PASS or FAIL, not TIMEOUT.
  - A store in the same cycle that `reset` is high is discarded; reset wins.
- Reset mid-operation, in any state: at the next edge the block returns to RUN and all outputs go to their reset values.
- `MemWrite` held high for k cycles counts as k stores. The first decisive one ends RUN; later cycles are ignored.
- No combinational path from inputs to outputs.

## Test plan
- Reset for 2 cycles, then a store of 0x00001000 to 252 → `pass`=1 and `done`=1 one cycle later; `store_count`=1, `last_adr`=252, `last_data`=0x00001000; flags stay unchanged for 20 more cycles.
- `STRICT`=1: store 0x00001000 to 248 → `fail`=1, `last_adr`=248. A later store of 0x00001000 to 252 leaves `fail`=1, `pass`=0 and `store_count`=1.
- `STRICT`=0: store 0x5 to 96, then 0x7 to 100, then 0x00000FFF to 252 → `fail`=1, `store_count`=3, `last_data`=0x00000FFF.
- `TIMEOUT_CYCLES`=50, no stores → `timeout`=1 at edge 50 after reset release and `cycles`=50. Repeat with the pass store in the 50th cycle → `pass`=1, `timeout`=0.
- After `pass`=1, assert `reset` for 1 cycle while `MemWrite`=1 (0x00001000 to 252) → all outputs 0 and state RUN; the store is not counted.
- `CNT_W`=2, `STRICT`=0: 5 stores to address 0 → `store_count` saturates at 3; state stays RUN.
